// File: rtl/wvb_channel_arbiter.sv
// Round-robin arbiter sharing one waveform consumer among N per-channel waveform buffers.
// Optional watchdog on a stalled grant: define WVB_ARB_TIMEOUT_EN.
module wvb_channel_arbiter #(
    parameter int N_CHANNELS   = 24,
    parameter int P_DATA_WIDTH = 170,
    parameter int P_HDR_WIDTH  = 80,
    parameter int P_IDX_WIDTH  = 5,
    parameter int P_TIMEOUT    = 65535
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic [N_CHANNELS-1:0]              chan_mask,
    input  logic [N_CHANNELS-1:0]              wvb_hdr_empty,
    input  logic [N_CHANNELS*P_DATA_WIDTH-1:0] wvb_data,
    input  logic [N_CHANNELS*P_HDR_WIDTH-1:0]  wvb_hdr_data,
    output logic [N_CHANNELS-1:0]              wvb_rdreq,
    output logic [N_CHANNELS-1:0]              wvb_hdr_rdreq,
    output logic [N_CHANNELS-1:0]              wvb_rddone,
    output logic                               out_hdr_empty,
    output logic [P_DATA_WIDTH-1:0]            out_data,
    output logic [P_HDR_WIDTH-1:0]             out_hdr_data,
    input  logic                               out_rdreq,
    input  logic                               out_hdr_rdreq,
    input  logic                               out_rddone,
    output logic                               grant_valid,
    output logic [P_IDX_WIDTH-1:0]             grant_idx,
    output logic                               timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [P_IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [P_IDX_WIDTH-1:0]  grant_idx_q, grant_idx_d;
    logic                    grant_valid_q, grant_valid_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [N_CHANNELS-1:0]   elig_s;
    logic [N_CHANNELS-1:0]   grant_onehot_s;
    logic [P_IDX_WIDTH-1:0]  pick_s;
    logic [P_IDX_WIDTH-1:0]  next_ptr_s;
    logic                    wdog_fire_s;
    logic                    end_grant_s;

    // First eligible index at or above ptr, wrapping; the descending scan lets the nearest hit win.
    function automatic logic [P_IDX_WIDTH-1:0] rr_pick(
        input logic [N_CHANNELS-1:0]  elig,
        input logic [P_IDX_WIDTH-1:0] ptr
    );
        logic [P_IDX_WIDTH-1:0] pick_v;
        logic [P_IDX_WIDTH-1:0] idx_v;
        int                     pos_v;
        pick_v = '0;
        for (int k = N_CHANNELS - 1; k >= 0; k--) begin
            pos_v = int'(ptr) + k;
            if (pos_v >= N_CHANNELS) begin
                pos_v = pos_v - N_CHANNELS;
            end
            idx_v = P_IDX_WIDTH'(pos_v);
            if (elig[idx_v]) begin
                pick_v = idx_v;
            end
        end
        return pick_v;
    endfunction

    assign elig_s      = chan_mask & ~wvb_hdr_empty;
    assign pick_s      = rr_pick(elig_s, rr_ptr_q);
    assign next_ptr_s  = (grant_idx_q == P_IDX_WIDTH'(N_CHANNELS - 1)) ? '0
                                                                       : grant_idx_q + P_IDX_WIDTH'(1);
    assign end_grant_s = out_rddone | wdog_fire_s;

`ifdef WVB_ARB_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;

    // Counter sits at zero outside GRANT, so it is already cleared on GRANT entry.
    always_comb begin
        wdog_d = 16'd0;
        if (state_q == ST_GRANT) begin
            wdog_d = wdog_q + 16'd1;
        end else begin
            wdog_d = 16'd0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= 16'd0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    // Fires in GRANT cycle P_TIMEOUT unless the consumer finishes in that same cycle.
    assign wdog_fire_s = (state_q == ST_GRANT) && (wdog_q == 16'(P_TIMEOUT - 1)) && !out_rddone;
`else
    assign wdog_fire_s = 1'b0;
`endif

    // Decoded grant vector; every steered strobe is gated through it.
    always_comb begin
        grant_onehot_s = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            grant_onehot_s[i] = (grant_idx_q == P_IDX_WIDTH'(i));
        end
    end

    // Next-state logic for the arbitration FSM.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_IDLE: begin
                if (en && (|elig_s)) begin
                    grant_idx_d   = pick_s;
                    grant_valid_d = 1'b1;
                    state_d       = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (end_grant_s) begin
                    rr_ptr_d      = next_ptr_s;
                    grant_valid_d = 1'b0;
                    timeout_err_d = timeout_err_q | wdog_fire_s;
                    state_d       = ST_HOLDOFF;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            ST_HOLDOFF: begin
                state_d = ST_IDLE;
            end
            default: begin
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Consumer-side mux and strobe steering; zero-latency path off the registered grant index.
    always_comb begin
        wvb_rdreq     = '0;
        wvb_hdr_rdreq = '0;
        wvb_rddone    = '0;
        out_hdr_empty = 1'b1;
        out_data      = '0;
        out_hdr_data  = '0;
        if (state_q == ST_GRANT) begin
            out_hdr_empty = |(wvb_hdr_empty & grant_onehot_s);
            for (int i = 0; i < N_CHANNELS; i++) begin
                if (grant_onehot_s[i]) begin
                    out_data     = wvb_data[i*P_DATA_WIDTH +: P_DATA_WIDTH];
                    out_hdr_data = wvb_hdr_data[i*P_HDR_WIDTH +: P_HDR_WIDTH];
                end
            end
            wvb_rdreq     = out_rdreq     ? grant_onehot_s : '0;
            wvb_hdr_rdreq = out_hdr_rdreq ? grant_onehot_s : '0;
            wvb_rddone    = end_grant_s   ? grant_onehot_s : '0;
        end else begin
            out_hdr_empty = 1'b1;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_wvb_channel_arbiter.sv
// Self-checking bench for wvb_channel_arbiter: directed table, corner sequences, random vs. model.
module tb_wvb_channel_arbiter;

    localparam int N  = 24;
    localparam int DW = 170;
    localparam int HW = 80;
    localparam int IW = 5;
`ifdef WVB_ARB_TIMEOUT_EN
    localparam int TO = 50;
`else
    localparam int TO = 65535;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [N-1:0]      chan_mask;
    logic [N-1:0]      wvb_hdr_empty;
    logic [N*DW-1:0]   wvb_data;
    logic [N*HW-1:0]   wvb_hdr_data;
    logic [N-1:0]      wvb_rdreq;
    logic [N-1:0]      wvb_hdr_rdreq;
    logic [N-1:0]      wvb_rddone;
    logic              out_hdr_empty;
    logic [DW-1:0]     out_data;
    logic [HW-1:0]     out_hdr_data;
    logic              out_rdreq;
    logic              out_hdr_rdreq;
    logic              out_rddone;
    logic              grant_valid;
    logic [IW-1:0]     grant_idx;
    logic              timeout_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    wvb_channel_arbiter #(
        .N_CHANNELS(N), .P_DATA_WIDTH(DW), .P_HDR_WIDTH(HW), .P_IDX_WIDTH(IW), .P_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .chan_mask(chan_mask), .wvb_hdr_empty(wvb_hdr_empty),
        .wvb_data(wvb_data), .wvb_hdr_data(wvb_hdr_data), .wvb_rdreq(wvb_rdreq),
        .wvb_hdr_rdreq(wvb_hdr_rdreq), .wvb_rddone(wvb_rddone), .out_hdr_empty(out_hdr_empty),
        .out_data(out_data), .out_hdr_data(out_hdr_data), .out_rdreq(out_rdreq),
        .out_hdr_rdreq(out_hdr_rdreq), .out_rddone(out_rddone), .grant_valid(grant_valid),
        .grant_idx(grant_idx), .timeout_err(timeout_err)
    );

    typedef struct {
        logic         en;
        logic [N-1:0] empty;
        logic         rdreq;
        logic         hdr_rdreq;
        logic         rddone;
        logic         gv;
        logic [IW-1:0] gidx;
        logic         he;
        logic [N-1:0] e_rdreq;
        logic [N-1:0] e_hdr_rdreq;
        logic [N-1:0] e_rddone;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic bitof(input logic [N-1:0] v, input int j);
        logic [N-1:0] t;
        t = v >> j;
        return t[0];
    endfunction

    function automatic logic [N-1:0] onehot(input int j);
        logic [N-1:0] t;
        t = 1;
        return t << j;
    endfunction

    function automatic logic [DW-1:0] data_of(input int j);
        return DW'(wvb_data >> (j * DW));
    endfunction

    function automatic logic [HW-1:0] hdr_of(input int j);
        return HW'(wvb_hdr_data >> (j * HW));
    endfunction

    task automatic randomize_data();
        for (int w = 0; w < (N * DW + 31) / 32; w++) wvb_data = (wvb_data << 32) | $urandom;
        for (int w = 0; w < (N * HW + 31) / 32; w++) wvb_hdr_data = (wvb_hdr_data << 32) | $urandom;
    endtask

    // Called at posedge+2 with inputs set; returns at posedge+3 of the first grant cycle.
    task automatic wait_grant(output int idx);
        int t;
        t = 0;
        #1;
        while (!grant_valid && t < 30) begin
            step();
            #1;
            t++;
        end
        chk("grant_seen", {255'd0, grant_valid}, 256'd1);
        idx = grant_valid ? int'(grant_idx) : -1;
    endtask

    // Holds the grant for 'hold' cycles in total, the last one carrying out_rddone.
    task automatic finish_grant(input int hold);
        repeat (hold - 1) step();
        out_rddone = 1'b1;
        step();
        out_rddone = 1'b0;
    endtask

    // Reference model state
    bit m_busy, m_cool, m_terr;
    int m_ptr, m_gidx, m_gcyc;

    initial begin
        int g;
        int fire_cyc;
        int order[6];
        logic [N-1:0] exp_rd, exp_hrd, exp_done;
        logic exp_he, fire, wd;

        rst_n = 1'b0; en = 1'b1; chan_mask = '1; wvb_hdr_empty = '1;
        out_rdreq = 1'b0; out_hdr_rdreq = 1'b0; out_rddone = 1'b0;
        wvb_data = '0; wvb_hdr_data = '0;
        randomize_data();
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Reset / idle with stray consumer strobes
        for (int c = 0; c < 100; c++) begin
            out_rdreq = 1'($urandom); out_hdr_rdreq = 1'($urandom); out_rddone = 1'($urandom);
            #1;
            chk("idle_state", {grant_valid, grant_idx, out_hdr_empty, timeout_err, wvb_rdreq, wvb_hdr_rdreq, wvb_rddone},
                {1'b0, 5'd0, 1'b1, 1'b0, 72'd0});
            chk("idle_data", {out_data, out_hdr_data}, 256'd0);
            step();
        end
        out_rdreq = 1'b0; out_hdr_rdreq = 1'b0; out_rddone = 1'b0;

        // Single channel 23, then wrap of rr_ptr to 0
        tbl[0]  = '{1'b1, 24'hFFFFFF, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 24'h0, 24'h0, 24'h0};
        tbl[1]  = '{1'b1, 24'h7FFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 24'h0, 24'h0, 24'h0};
        tbl[2]  = '{1'b1, 24'h7FFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 5'd23, 1'b0, 24'h0, 24'h800000, 24'h0};
        tbl[3]  = '{1'b1, 24'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 5'd23, 1'b0, 24'h800000, 24'h0, 24'h0};
        tbl[4]  = '{1'b1, 24'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 5'd23, 1'b0, 24'h800000, 24'h0, 24'h0};
        tbl[5]  = '{1'b1, 24'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 5'd23, 1'b0, 24'h800000, 24'h0, 24'h0};
        tbl[6]  = '{1'b1, 24'h7FFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 5'd23, 1'b0, 24'h800000, 24'h0, 24'h0};
        tbl[7]  = '{1'b1, 24'h7FFFFF, 1'b1, 1'b0, 1'b1, 1'b1, 5'd23, 1'b0, 24'h800000, 24'h0, 24'h800000};
        tbl[8]  = '{1'b1, 24'hFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 5'd23, 1'b1, 24'h0, 24'h0, 24'h0};
        tbl[9]  = '{1'b1, 24'h7FFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 5'd23, 1'b1, 24'h0, 24'h0, 24'h0};
        tbl[10] = '{1'b1, 24'h7FFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 24'h0, 24'h0, 24'h0};
        tbl[11] = '{1'b1, 24'h7FFFFE, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 24'h0, 24'h0, 24'h000001};
        tbl[12] = '{1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 24'h0, 24'h0, 24'h0};
        for (int i = 0; i < 13; i++) begin
            en = tbl[i].en; wvb_hdr_empty = tbl[i].empty;
            out_rdreq = tbl[i].rdreq; out_hdr_rdreq = tbl[i].hdr_rdreq; out_rddone = tbl[i].rddone;
            #1;
            chk("tbl_grant", {grant_valid, grant_idx}, {tbl[i].gv, tbl[i].gidx});
            chk("tbl_hdr_empty", {255'd0, out_hdr_empty}, {255'd0, tbl[i].he});
            chk("tbl_rdreq", wvb_rdreq, tbl[i].e_rdreq);
            chk("tbl_hdr_rdreq", wvb_hdr_rdreq, tbl[i].e_hdr_rdreq);
            chk("tbl_rddone", wvb_rddone, tbl[i].e_rddone);
            chk("tbl_data", {out_data, out_hdr_data},
                tbl[i].gv ? {data_of(int'(tbl[i].gidx)), hdr_of(int'(tbl[i].gidx))} : 250'd0);
            step();
        end
        out_rdreq = 1'b0; out_hdr_rdreq = 1'b0; out_rddone = 1'b0;

        // Round-robin among 2, 5, 20
        wvb_hdr_empty = ~(onehot(2) | onehot(5) | onehot(20));
        for (int k = 0; k < 6; k++) begin
            wait_grant(g);
            order[k] = g;
            finish_grant(10);
        end
        for (int k = 0; k < 6; k++) chk("rr_order", 256'(order[k]), (k % 3 == 0) ? 256'd2 : (k % 3 == 1) ? 256'd5 : 256'd20);

        // Mask and enable
        chan_mask = ~onehot(5);
        wvb_hdr_empty = ~(onehot(2) | onehot(5));
        wait_grant(g);
        chk("mask_grant", 256'(g), 256'd2);
        en = 1'b0;
        repeat (3) step();
        #1;
        chk("en_drop_hold", {grant_valid, grant_idx}, {1'b1, 5'd2});
        finish_grant(1);
        for (int c = 0; c < 20; c++) begin
            #1;
            chk("en_low_no_grant", {255'd0, grant_valid}, 256'd0);
            step();
        end
        en = 1'b1;
        wait_grant(g);
        chk("en_back_grant", 256'(g), 256'd2);

        // Reset mid-GRANT with strobes active
        out_rdreq = 1'b1; out_rddone = 1'b1; rst_n = 1'b0;
        #1;
        chk("rst_mid_grant", {grant_valid, grant_idx, out_hdr_empty, timeout_err, wvb_rdreq, wvb_rddone},
            {1'b0, 5'd0, 1'b1, 1'b0, 48'd0});
        chk("rst_mid_data", {out_data, out_hdr_data}, 256'd0);
        step();
        rst_n = 1'b1; out_rdreq = 1'b0; out_rddone = 1'b0; chan_mask = '1;

        // Watchdog
        wvb_hdr_empty = ~(onehot(3) | onehot(7));
        wait_grant(g);
        chk("wd_grant", 256'(g), 256'd3);
`ifdef WVB_ARB_TIMEOUT_EN
        fire_cyc = -1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (wvb_rddone[3]) begin
                fire_cyc = cyc;
                break;
            end
            chk("wd_quiet", {wvb_rddone, timeout_err}, 25'd0);
            step();
            #1;
        end
        chk("wd_fire_cycle", 256'(fire_cyc), 256'(TO));
        step();
        #1;
        chk("wd_err_set", {grant_valid, timeout_err}, 2'b01);
        repeat (2) step();
        #1;
        chk("wd_next_grant", {grant_valid, grant_idx, timeout_err}, {1'b1, 5'd7, 1'b1});
        finish_grant(1);
`else
        fire_cyc = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            chk("wd_hold", {grant_valid, grant_idx, timeout_err, wvb_rddone}, {1'b1, 5'd3, 1'b0, 24'd0});
            step();
            #1;
        end
        chk("wd_hold_cycles", 256'(fire_cyc), 256'd0);
        finish_grant(1);
`endif

        // Random stimulus against the reference model
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_busy = 0; m_cool = 0; m_terr = 0; m_ptr = 0; m_gidx = 0; m_gcyc = 0;
        for (int c = 0; c < 3000; c++) begin
            en = ($urandom % 8) != 0;
            chan_mask = N'($urandom | $urandom);
            wvb_hdr_empty = ($urandom % 4 == 0) ? '1 : N'($urandom & $urandom);
            out_rdreq = 1'($urandom); out_hdr_rdreq = 1'($urandom);
            out_rddone = ($urandom % 6) == 0;
            randomize_data();
            #1;
            wd = 1'b0;
`ifdef WVB_ARB_TIMEOUT_EN
            wd = m_busy && (m_gcyc == TO) && !out_rddone;
`endif
            fire = m_busy && (out_rddone || wd);
            exp_he = m_busy ? bitof(wvb_hdr_empty, m_gidx) : 1'b1;
            exp_rd = (m_busy && out_rdreq) ? onehot(m_gidx) : '0;
            exp_hrd = (m_busy && out_hdr_rdreq) ? onehot(m_gidx) : '0;
            exp_done = fire ? onehot(m_gidx) : '0;
            chk("rnd_grant", {grant_valid, grant_idx, timeout_err}, {m_busy, IW'(m_gidx), m_terr});
            chk("rnd_hdr_empty", {255'd0, out_hdr_empty}, {255'd0, exp_he});
            chk("rnd_strobes", {wvb_rdreq, wvb_hdr_rdreq, wvb_rddone}, {exp_rd, exp_hrd, exp_done});
            chk("rnd_data", {out_data, out_hdr_data}, m_busy ? {data_of(m_gidx), hdr_of(m_gidx)} : 250'd0);
            if (m_busy) begin
                if (fire) begin
                    m_busy = 0; m_cool = 1;
                    m_ptr = (m_gidx + 1) % N;
                    if (wd) m_terr = 1;
                end else begin
                    m_gcyc++;
                end
            end else if (m_cool) begin
                m_cool = 0;
            end else if (en && ((chan_mask & ~wvb_hdr_empty) != '0)) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (bitof(chan_mask & ~wvb_hdr_empty, (m_ptr + k) % N)) m_gidx = (m_ptr + k) % N;
                end
                m_busy = 1; m_gcyc = 1;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
